max_pool_ctrl: RTL and testbench
================================

Name: max_pool_ctrl

Overview:
Sequential controller that runs max pooling over one feature-map plane held in on-chip SRAM. It walks every output position and issues one SRAM read per window element. Each window is reduced through a running-max register using a signed fixed-point compare. Each pooled result goes out through a valid/ready write port. It sits between the layer scheduler (start/done) and the feature-map SRAM / output buffer.

Parameters:
DATA_W, 32, word width of feature-map samples (signed two's complement fixed point)
FRAC_W, 16, fractional bits; informational only, since the compare is format-independent
WIN, 2, pooling window edge (WIN x WIN elements)
STRIDE, 2, window step in x and y
IMG_W, 8, input plane width
IMG_H, 8, input plane height
ADDR_W, 16, SRAM address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to pool one plane; sampled only in IDLE
in_base  input  ADDR_W  base address of input plane; latched on accepted start
out_base  input  ADDR_W  base address of output plane; latched on accepted start
busy  output  1  high from the cycle after start is accepted through the DONE state
done  output  1  one-cycle pulse when the last output has been accepted
rd_en  output  1  SRAM read strobe
rd_addr  output  ADDR_W  SRAM read address
rd_data  input  DATA_W  SRAM read data; valid exactly 1 cycle after rd_en
out_valid  output  1  pooled result available
out_ready  input  1  downstream accepts the result
out_data  output  DATA_W  pooled maximum
out_addr  output  ADDR_W  destination address of the result

Behaviour:
- Derived sizes: OUT_W = (IMG_W-WIN)/STRIDE+1 and OUT_H = (IMG_H-WIN)/STRIDE+1. Counters: ox, oy over the output grid; kx, ky over the window.
- Reset, and the IDLE state: busy=0, done=0, rd_en=0, out_valid=0. rd_addr, out_data and out_addr are all 0. All counters are 0. The state goes to IDLE.
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 latches in_base and out_base, clears the counters, and moves to READ.
  - start in any other state is ignored.
- READ:
  - rd_en=1 every cycle.
  - rd_addr = in_base + (oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx.
  - kx increments fastest; it wraps at WIN-1, and on wrap ky increments.
  - After the (WIN*WIN)-th issue, move to DRAIN.
- Running max:
  - The datum returning for the first element (kx=ky=0) loads max_r unconditionally.
  - Each later datum replaces max_r only if it is strictly greater (signed compare). Equal values keep the older one.
- DRAIN: one cycle with rd_en=0 to capture the final datum, then go to WRITE.
- WRITE:
  - out_valid=1, out_data=max_r, out_addr = out_base + oy*OUT_W + ox.
  - All three signals hold stable until out_ready=1.
  - On the handshake, advance ox (wrapping at OUT_W-1, which increments oy).
  - Next state is READ, or DONE if this was the last position (ox=OUT_W-1, oy=OUT_H-1).
  - out_ready while out_valid=0 has no effect.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE (busy=0).
- Timing with out_ready tied high: per window, WIN*WIN READ cycles + 1 DRAIN + 1 WRITE.
  - Start accepted at cycle 0 gives the first out_valid at cycle WIN*WIN+2.
  - done arrives at cycle OUT_W*OUT_H*(WIN*WIN+2)+1.
- Backpressure: the FSM stalls in WRITE indefinitely and no reads are issued while stalled.
- reset mid-operation: synchronous abort to the IDLE values on the next edge, with no done pulse. A start presented in the same cycle as reset is dropped.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.

Optional Feature:
MAX_POOL_RELU_EN
- Defined: out_data = (max_r < 0) ? 0 : max_r, i.e. fused ReLU. Timing is unchanged.
- Undefined: out_data = max_r, including negative values.

Decomposition:
- Package max_pool_pkg holds:
  - the FSM state encoding localparams (IDLE..DONE);
  - the OUT_W/OUT_H derivation functions;
  - a signed_gt(a,b) function for DATA_W-wide compare.
- One sub-module, max_pool_addr_gen, contains the ox/oy/kx/ky counters and the rd_addr/out_addr computation. It takes step/advance strobes from the FSM and returns last_elem and last_pos flags.

Test Plan:
- IMG=4x4, WIN=2, STRIDE=2, in_base=0x10, out_base=0x80, data = address index 0..15, out_ready=1.
  - Outputs 5, 7, 13, 15 at out_addr 0x80..0x83, with out_valid at cycles 6, 12, 18, 24.
  - done pulse at cycle 25.
- Same plane with all values negative (-16..-1, data = -16+index).
  - Outputs -11, -9, -3, -1.
  - With MAX_POOL_RELU_EN defined, all four outputs are 0.
- Ties: window values {3,3,3,3}. Output is 3, and max_r updates only on the first load.
- Backpressure: hold out_ready=0 for 5 cycles at the first WRITE.
  - out_valid, out_data and out_addr stay stable and rd_en stays 0.
  - The result is accepted on the first ready cycle and the sequence resumes.
- Assert reset during the third READ cycle of window 1.
  - Next cycle: all outputs 0, busy=0, no done pulse.
  - A subsequent start rerun gives the full correct result.
- Pulse start while busy=1. The pulse is ignored: no base re-latch and no counter disturbance.

Source files
------------

// File: rtl/max_pool_pkg.sv
// Shared types and helpers for the max-pooling controller.
package max_pool_pkg;

    localparam int unsigned PKG_DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Output-grid edge for one axis of a valid (unpadded) pooling.
    function automatic int unsigned out_dim(input int unsigned img,
                                            input int unsigned win,
                                            input int unsigned stride);
        return (img - win) / stride + 1;
    endfunction

    function automatic int unsigned out_w(input int unsigned img_w,
                                          input int unsigned win,
                                          input int unsigned stride);
        return out_dim(img_w, win, stride);
    endfunction

    function automatic int unsigned out_h(input int unsigned img_h,
                                          input int unsigned win,
                                          input int unsigned stride);
        return out_dim(img_h, win, stride);
    endfunction

    // Two's-complement compare; independent of where the binary point sits.
    function automatic logic signed_gt(input logic [PKG_DATA_W-1:0] a,
                                       input logic [PKG_DATA_W-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

endpackage

// File: rtl/max_pool_addr_gen.sv
// Output-grid and window counters with registered SRAM read and result write addresses.
module max_pool_addr_gen #(
    parameter int unsigned WIN    = 2,
    parameter int unsigned STRIDE = 2,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned OUT_H  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              advance_i,
    input  logic              go_idle_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] out_base_i,
    output logic              first_elem_o,
    output logic              last_elem_o,
    output logic              last_pos_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN - 1);
    localparam logic [ADDR_W-1:0] OX_LAST  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OY_LAST  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(OUT_W);

    logic [ADDR_W-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, out_addr_q, out_addr_d;
    logic              first_elem_q, last_elem_q, last_pos_q;

    // Addresses are derived from next-state counters so the registered copies track the counters.
    always_comb begin
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        if (go_idle_i) begin
            kx_d       = '0;
            ky_d       = '0;
            ox_d       = '0;
            oy_d       = '0;
            in_base_d  = '0;
            out_base_d = '0;
        end else if (clear_i) begin
            kx_d       = '0;
            ky_d       = '0;
            ox_d       = '0;
            oy_d       = '0;
            in_base_d  = in_base_i;
            out_base_d = out_base_i;
        end else if (step_i) begin
            if (kx_q == WIN_LAST) begin
                kx_d = '0;
                ky_d = (ky_q == WIN_LAST) ? '0 : ky_q + 1'b1;
            end else begin
                kx_d = kx_q + 1'b1;
            end
        end else if (advance_i) begin
            kx_d = '0;
            ky_d = '0;
            if (ox_q == OX_LAST) begin
                ox_d = '0;
                oy_d = (oy_q == OY_LAST) ? '0 : oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
        rd_addr_d  = in_base_d + (oy_d * STRIDE_A + ky_d) * IMG_W_A + ox_d * STRIDE_A + kx_d;
        out_addr_d = out_base_d + oy_d * OUT_W_A + ox_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kx_q         <= '0;
            ky_q         <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            rd_addr_q    <= '0;
            out_addr_q   <= '0;
            first_elem_q <= 1'b1;
            last_elem_q  <= (WIN == 1);
            last_pos_q   <= (OUT_W == 1) && (OUT_H == 1);
        end else begin
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            in_base_q    <= in_base_d;
            out_base_q   <= out_base_d;
            rd_addr_q    <= rd_addr_d;
            out_addr_q   <= out_addr_d;
            first_elem_q <= (kx_d == '0) && (ky_d == '0);
            last_elem_q  <= (kx_d == WIN_LAST) && (ky_d == WIN_LAST);
            last_pos_q   <= (ox_d == OX_LAST) && (oy_d == OY_LAST);
        end
    end

    assign first_elem_o = first_elem_q;
    assign last_elem_o  = last_elem_q;
    assign last_pos_o   = last_pos_q;
    assign rd_addr_o    = rd_addr_q;
    assign out_addr_o   = out_addr_q;

endmodule

// File: rtl/max_pool_ctrl.sv
// Max-pooling controller: walks one SRAM plane, reduces each window, emits results on valid/ready.
// Define MAX_POOL_RELU_EN to clamp negative pooled results to zero (fused ReLU).
module max_pool_ctrl
    import max_pool_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned WIN    = 2,
    parameter int unsigned STRIDE = 2,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int unsigned OUT_W = out_w(IMG_W, WIN, STRIDE);
    localparam int unsigned OUT_H = out_h(IMG_H, WIN, STRIDE);

    // The compare helper is fixed-width; the binary point never affects ordering.
    if (DATA_W != PKG_DATA_W || FRAC_W >= DATA_W) begin : g_bad_cfg
        $error("max_pool_ctrl: DATA_W must equal PKG_DATA_W and exceed FRAC_W");
    end

    state_e            state_q, state_d;
    logic              clear, step, advance, go_idle;
    logic              first_elem, last_elem, last_pos;
    logic              busy_q, done_q, rd_en_q, out_valid_q;
    logic              valid_q, first_q;
    logic [DATA_W-1:0] max_q, max_d, pooled, out_data_q, out_data_d;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        step    = 1'b0;
        advance = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                step = 1'b1;
                if (last_elem) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                if (out_ready) begin
                    advance = 1'b1;
                    state_d = last_pos ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                go_idle = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                go_idle = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Running max over data returning one cycle after each read; ties keep the older value.
    always_comb begin
        max_d = max_q;
        if (valid_q && (first_q || signed_gt(rd_data, max_q))) max_d = rd_data;
`ifdef MAX_POOL_RELU_EN
        pooled = max_d[DATA_W-1] ? '0 : max_d;
`else
        pooled = max_d;
`endif
        out_data_d = out_data_q;
        if (state_d == S_IDLE)       out_data_d = '0;
        else if (state_q == S_DRAIN) out_data_d = pooled;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            max_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            rd_en_q     <= (state_d == S_READ);
            out_valid_q <= (state_d == S_WRITE);
            out_data_q  <= out_data_d;
            valid_q     <= (state_q == S_READ);
            first_q     <= (state_q == S_READ) && first_elem;
            max_q       <= max_d;
        end
    end

    max_pool_addr_gen #(
        .WIN    (WIN),
        .STRIDE (STRIDE),
        .IMG_W  (IMG_W),
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear),
        .step_i       (step),
        .advance_i    (advance),
        .go_idle_i    (go_idle),
        .in_base_i    (in_base),
        .out_base_i   (out_base),
        .first_elem_o (first_elem),
        .last_elem_o  (last_elem),
        .last_pos_o   (last_pos),
        .rd_addr_o    (rd_addr),
        .out_addr_o   (out_addr)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Directed bench for max_pool_ctrl on a 4x4 plane, 2x2 window, stride 2 (MAX_POOL_RELU_EN aware).
module tb_max_pool_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_base = '0;
    logic [15:0] out_base = '0;
    logic        busy, done, rd_en, out_valid;
    logic [15:0] rd_addr, out_addr;
    logic [31:0] rd_data = '0;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    max_pool_ctrl #(
        .DATA_W (32),
        .FRAC_W (16),
        .WIN    (2),
        .STRIDE (2),
        .IMG_W  (4),
        .IMG_H  (4),
        .ADDR_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_base   (in_base),
        .out_base  (out_base),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr)
    );

    // SRAM model: one-cycle read latency, plane fixed at 0x10; stray addresses return a poison word.
    logic [31:0] mem [16];
    logic [15:0] mem_off;
    assign mem_off = rd_addr - 16'h0010;
    always @(posedge clk) begin
        if (rd_en) rd_data <= (mem_off < 16'd16) ? mem[mem_off[3:0]] : 32'h7fff_0000;
    end

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int k      = 0;
    int exp_v [4];
    int mixed [16] = '{-5, 7, -20, -30, -100, 0, -2, -40, 100, 100, -1000, -999, 50, -1, -1001, -1000};

    function automatic int post(input int v);
`ifdef MAX_POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic load_plane(input int kind);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       mem[i] = 32'(i);
                1:       mem[i] = 32'(i - 16);
                2:       mem[i] = 32'(mixed[i]);
                default: mem[i] = 32'd3;
            endcase
        end
    endtask

    task automatic do_start();
        in_base  = 16'h0010;
        out_base = 16'h0080;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = 1;
    endtask

    // Gathers results n=first_n..3, checks value/address/cycle, then the done pulse and idle values.
    task automatic collect(input int first_n, input int off);
        int n;
        n = first_n;
        while (n < 4 && k < 200) begin
            if (out_valid) begin
                chk($sformatf("data%0d", n), out_data, 32'(exp_v[n]));
                chk($sformatf("addr%0d", n), 32'(out_addr), 32'(32'h80 + n));
                chk($sformatf("valid_cycle%0d", n), 32'(k), 32'(6 * (n + 1) + off));
                n++;
            end
            tick();
        end
        chk("outputs_seen", 32'(n), 32'd4);
        while (!done && k < 200) tick();
        chk("done_cycle", 32'(k), 32'(25 + off));
        chk("busy_at_done", 32'(busy), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rd_addr", 32'(rd_addr), 32'd0);
        chk("idle_out_data", out_data, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);

        // Ascending plane: maxima are the bottom-right element of each window.
        load_plane(0);
        exp_v = '{5, 7, 13, 15};
        do_start();
        collect(0, 0);

        // All-negative plane.
        load_plane(1);
        exp_v = '{post(-11), post(-9), post(-3), post(-1)};
        do_start();
        collect(0, 0);

        // Mixed signs, decreasing maxima across windows, and an equal-value pair.
        load_plane(2);
        exp_v = '{post(7), post(-2), post(100), post(-999)};
        do_start();
        collect(0, 0);

        // Uniform plane of ties.
        load_plane(3);
        exp_v = '{3, 3, 3, 3};
        do_start();
        collect(0, 0);

        // Backpressure: hold out_ready low for five cycles at the first WRITE.
        load_plane(0);
        exp_v = '{5, 7, 13, 15};
        out_ready = 1'b0;
        do_start();
        while (!out_valid && k < 50) tick();
        chk("bp_first_valid_cycle", 32'(k), 32'd6);
        chk("bp_data", out_data, 32'd5);
        chk("bp_addr", 32'(out_addr), 32'h80);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_data%0d", i), out_data, 32'd5);
            chk($sformatf("bp_hold_addr%0d", i), 32'(out_addr), 32'h80);
            chk($sformatf("bp_hold_rd_en%0d", i), 32'(rd_en), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_rd_en", 32'(rd_en), 32'd1);
        collect(1, 5);

        // Reset during the third READ of window 1, with a start presented alongside it.
        do_start();
        while (k < 9) tick();
        chk("abort_pre_rd_en", 32'(rd_en), 32'd1);
        chk("abort_pre_rd_addr", 32'(rd_addr), 32'h16);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_rd_addr", 32'(rd_addr), 32'd0);
        chk("abort_out_data", out_data, 32'd0);
        chk("abort_out_addr", 32'(out_addr), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_quiet_busy%0d", i), 32'(busy), 32'd0);
            chk($sformatf("abort_quiet_done%0d", i), 32'(done), 32'd0);
        end
        do_start();
        collect(0, 0);

        // Start pulse with different bases while busy must be ignored.
        do_start();
        while (k < 3) tick();
        in_base  = 16'h0040;
        out_base = 16'h0090;
        start    = 1'b1;
        tick();
        start = 1'b0;
        collect(0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
